// File: rtl/spi_key_pkg.sv
// spi_key_pkg: shared state encoding, default sizes and odd-parity helper for spi_key_loader
package spi_key_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, COMMIT, DONE, ERR_WAIT} state_t;
  localparam int DEF_KEY_W = 48;
  localparam int DEF_NUM_KEYS = 16;
  function automatic logic odd_par(input logic [255:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one async input with rise/fall detect
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= {sr[STAGES-2:0], din};
      prev <= sr[STAGES-1];
    end
  assign q = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_key_loader.sv
// spi_key_loader: framed serial round-key loader with atomic commit; SPI_KEY_PARITY_EN adds per-key odd parity
module spi_key_loader
  import spi_key_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      spi_clk,
  input  logic                      spi_cs_n,
  input  logic                      spi_data,
  output logic [NUM_KEYS*KEY_W-1:0] key_bus,
  output logic                      keys_valid,
  output logic                      load_done,
  output logic                      frame_err,
  output logic                      busy
);
  localparam int BW = $clog2(KEY_W);
  localparam int KW = $clog2(NUM_KEYS);
  state_t state, state_n;
  logic [BW-1:0] bit_cnt;
  logic [KW-1:0] key_idx;
  logic [NUM_KEYS*KEY_W-1:0] shadow;
  logic [KEY_W-1:0] cur_key;
  logic smp, clk_q, clk_fall, cs_q, cs_rise, cs_fall, data_q, d_rise, d_fall;
  logic key_last, idx_last, err_n, unused_edges;
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_clk (.clk(clk), .reset(reset), .din(spi_clk), .q(clk_q), .rise(smp), .fall(clk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk), .reset(reset), .din(spi_cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_dat (.clk(clk), .reset(reset), .din(spi_data), .q(data_q), .rise(d_rise), .fall(d_fall));
  assign unused_edges = ^{clk_q, clk_fall, d_rise, d_fall};
  assign cur_key = shadow[int'(key_idx)*KEY_W +: KEY_W];
  assign key_last = bit_cnt == BW'(KEY_W-1);
  assign idx_last = key_idx == KW'(NUM_KEYS-1);
  assign busy = state == SHIFT;
`ifdef SPI_KEY_PARITY_EN
  logic par_ok;
  assign par_ok = data_q == odd_par(256'(cur_key));
`endif
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_n = SHIFT;
`ifdef SPI_KEY_PARITY_EN
      SHIFT: if (smp && key_last) state_n = PARITY;
      PARITY: if (smp) begin
        state_n = par_ok ? (idx_last ? COMMIT : SHIFT) : ERR_WAIT;
        err_n = ~par_ok;
      end
`else
      SHIFT: if (smp && key_last && idx_last) state_n = COMMIT;
`endif
      COMMIT: state_n = DONE;
      DONE, ERR_WAIT: if (cs_q) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // frame end is judged after this cycle's sample, so a last bit coinciding with cs_n rise still commits
    if (cs_rise && (state_n == SHIFT || state_n == PARITY)) begin
      state_n = IDLE;
      err_n = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      key_idx <= '0;
      shadow <= '0;
      key_bus <= '0;
      keys_valid <= 1'b0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      load_done <= state == COMMIT;
      frame_err <= err_n;
      if (state == IDLE && cs_fall) begin
        bit_cnt <= '0;
        key_idx <= '0;
      end
      if (state == SHIFT && smp) begin
        shadow[int'(key_idx)*KEY_W +: KEY_W] <= {cur_key[KEY_W-2:0], data_q};
        bit_cnt <= key_last ? '0 : bit_cnt + 1'b1;
`ifndef SPI_KEY_PARITY_EN
        if (key_last) key_idx <= key_idx + 1'b1;
`endif
      end
`ifdef SPI_KEY_PARITY_EN
      if (state == PARITY && smp) key_idx <= key_idx + 1'b1;
`endif
      if (state == COMMIT) begin
        key_bus <= shadow;
        keys_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_key_loader.sv
// tb_spi_key_loader: directed frames against hand-chosen keys; honours SPI_KEY_PARITY_EN
module tb_spi_key_loader;
  logic clk = 0, reset = 1, spi_clk = 0, spi_cs_n = 1, spi_data = 0;
  logic [767:0] key_bus;
  logic keys_valid, load_done, frame_err, busy;
  logic [47:0] tx [16];
  logic [767:0] pk_a, pk_f, exp_a = '0, exp_b = '0;
  int errors = 0, checks = 0, n_done = 0, n_err = 0, mix_bad = 0;
  spi_key_loader dut (.clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_data(spi_data),
    .key_bus(key_bus), .keys_valid(keys_valid), .load_done(load_done), .frame_err(frame_err), .busy(busy));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (load_done) n_done++;
    if (frame_err) n_err++;
    if (key_bus !== exp_a && key_bus !== exp_b) mix_bad++;
  end
  task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [767:0] pack();
    logic [767:0] p;
    for (int k = 0; k < 16; k++) p[k*48 +: 48] = tx[k];
    return p;
  endfunction
  task automatic send_bit(input logic b);
    spi_data = b;
    repeat (3) @(negedge clk);
    spi_clk = 1;
    repeat (3) @(negedge clk);
    spi_clk = 0;
  endtask
  task automatic frame(input int stop_at, input int extra, input int bad_par);
    int n = 0;
    spi_cs_n = 0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      for (int i = 47; i >= 0; i--) if (n < stop_at) begin send_bit(tx[k][i]); n++; end
`ifdef SPI_KEY_PARITY_EN
      if (n < stop_at) begin send_bit(~^tx[k] ^ (k == bad_par)); n++; end
`endif
    end
    repeat (extra) send_bit(1'b1);
    repeat (3) @(negedge clk);
    spi_cs_n = 1;
    repeat (10) @(negedge clk);
  endtask
  task automatic load_a();
    for (int k = 0; k < 16; k++) tx[k] = 48'h0123456789ab ^ (48'(k) * 48'h111111111111);
    tx[0] = 48'h38acef46564a;
    tx[15] = 48'hd33a2d238d68;
  endtask
  initial begin
    load_a();
    pk_a = pack();
    for (int k = 0; k < 16; k++) tx[k] = 48'hffffffffffff;
    pk_f = pack();
    repeat (3) @(negedge clk);
    chk("reset_key_bus", key_bus, '0);
    chk("reset_keys_valid", 768'(keys_valid), '0);
    chk("reset_load_done", 768'(load_done), '0);
    chk("reset_frame_err", 768'(frame_err), '0);
    chk("reset_busy", 768'(busy), '0);
    reset = 0;
    repeat (5) @(negedge clk);
    load_a();
    exp_b = pk_a;
    frame(1 << 30, 0, -1);
    chk("a_done_cnt", 768'(n_done), 768'(1));
    chk("a_err_cnt", 768'(n_err), 768'(0));
    chk("a_key_bus", key_bus, pk_a);
    chk("a_valid", 768'(keys_valid), 768'(1));
    chk("a_busy_idle", 768'(busy), 768'(0));
    exp_a = pk_a;
    for (int k = 0; k < 16; k++) tx[k] = 48'h555555555555;
    frame(100, 0, -1);
    chk("abort_err_cnt", 768'(n_err), 768'(1));
    chk("abort_done_cnt", 768'(n_done), 768'(1));
    chk("abort_key_bus", key_bus, pk_a);
    chk("abort_valid", 768'(keys_valid), 768'(1));
    for (int k = 0; k < 16; k++) tx[k] = 48'hffffffffffff;
    exp_b = pk_f;
    frame(1 << 30, 0, -1);
    chk("f_done_cnt", 768'(n_done), 768'(2));
    chk("f_key_bus", key_bus, pk_f);
    chk("f_no_mix", 768'(mix_bad), 768'(0));
    load_a();
    exp_a = pk_f;
    exp_b = pk_a;
    frame(1 << 30, 8, -1);
    chk("extra_done_cnt", 768'(n_done), 768'(3));
    chk("extra_err_cnt", 768'(n_err), 768'(1));
    chk("extra_key_bus", key_bus, pk_a);
    chk("extra_no_mix", 768'(mix_bad), 768'(0));
    exp_a = pk_a;
`ifdef SPI_KEY_PARITY_EN
    for (int k = 0; k < 16; k++) tx[k] = 48'hffffffffffff;
    frame(1 << 30, 0, 3);
    chk("par_err_cnt", 768'(n_err), 768'(2));
    chk("par_done_cnt", 768'(n_done), 768'(3));
    chk("par_key_bus", key_bus, pk_a);
    load_a();
`endif
    exp_b = '0;
    spi_cs_n = 0;
    repeat (4) @(negedge clk);
    for (int n = 0; n < 200; n++) send_bit(n[0]);
    chk("mid_busy", 768'(busy), 768'(1));
    #2 reset = 1;
    #1;
    chk("rst_key_bus", key_bus, '0);
    chk("rst_valid", 768'(keys_valid), '0);
    chk("rst_busy", 768'(busy), '0);
    spi_cs_n = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    n_done = 0;
    n_err = 0;
    exp_b = pk_a;
    frame(1 << 30, 0, -1);
    chk("post_done_cnt", 768'(n_done), 768'(1));
    chk("post_err_cnt", 768'(n_err), 768'(0));
    chk("post_key_bus", key_bus, pk_a);
    chk("post_valid", 768'(keys_valid), 768'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
